nios2_oci_dct_sequencer: RTL
============================

// Module: nios2_oci_dct_sequencer
// PURPOSE
//  Capture controller for the OCI debug compressed-trace (DCT) buffer. Arms on request, starts on
//  trigger, packs 2-bit trace codes LSB-first into a 30-bit buffer, and hands full or flushed
//  words to a downstream trace sink over valid/ready. Drives the dct_buffer/dct_count/test_ending/
//  test_has_ended signals that the OCI test bench samples.
// PARAMETERS
//  CODE_W   2   bits per trace code
//  DEPTH    15  codes per buffer word; BUF_W = CODE_W*DEPTH = 30, CNT_W = 4
// PORTS
//  clk             in   1      single clock, all logic rising-edge
//  reset_n         in   1      asynchronous active-low reset
//  arm             in   1      pulse: IDLE/DONE -> ARMED
//  trigger         in   1      ARMED -> CAPTURE
//  stop            in   1      ARMED/CAPTURE -> DRAIN
//  code_valid      in   1      trace code present this cycle
//  code            in   2      trace code
//  dct_buffer      out  30     packing buffer, slot i = bits [2i+1:2i]
//  dct_count       out  4      valid codes in dct_buffer, 0..15
//  out_valid       out  1      output word pending
//  out_ready       in   1      sink accepts when out_valid & out_ready
//  out_data        out  30     emitted word
//  out_count       out  4      valid codes in out_data (15 unless flush)
//  overflow        out  1      sticky: at least one code dropped
//  test_ending     out  1      high while in DRAIN
//  test_has_ended  out  1      high while in DONE
// BEHAVIOUR
//  Reset: state IDLE; every output 0.
//  States: IDLE -arm-> ARMED -trigger-> CAPTURE -stop-> DRAIN -empty-> DONE -arm-> ARMED.
//   stop in ARMED -> DRAIN; stop has priority over a simultaneous trigger. arm in DONE clears
//   overflow and test_has_ended. arm/trigger/stop are ignored in every other state.
//  Capture: codes are accepted in CAPTURE only, including the trigger cycle's code.
//   An accepted code is written to slot dct_count; dct_count increments.
//  Out register "free" = !out_valid | out_ready.
//   Accepted code with dct_count==14 and out free: {code,buf[27:0]} -> out_data, out_count=15,
//   out_valid=1 next cycle (1-cycle latency); buffer cleared, dct_count=0.
//   Same case with out not free: buffer holds the full word, dct_count=15 (stalled).
//   Stalled and out free: word moves out; a code in that same cycle lands in slot 0, count=1.
//   Stalled and out not free: code dropped, overflow=1.
//  DRAIN: codes ignored. When dct_count>0 and out free, the partial word moves out with
//   out_count=dct_count. When dct_count==0 and out_valid==0 -> DONE (DRAIN lasts at least 1 cycle).
//  out_valid holds with data stable until accepted; out_valid drops after acceptance unless a new
//   word is loaded in the same cycle.
//  reset_n low mid-capture: immediate clear; buffered and pending data are discarded.
// CONFIGURATION
//  DCT_DROP_COUNT_EN defined: adds output drop_count[15:0], incremented per dropped code,
//   saturates at 16'hFFFF, cleared by reset and by arm in DONE.
//  Not defined: the port is absent; overflow flag only.
// STRUCTURE
//  Package nios2_oci_dct_pkg: state enum (IDLE, ARMED, CAPTURE, DRAIN, DONE),
//   CODE_W/DEPTH/BUF_W/CNT_W constants.
//  Sub-module nios2_oci_dct_outreg: single-entry valid/ready output register
//   (data+count), exposes its free signal.
// TESTING
//  arm, trigger, 15 codes 2'b01 with out_ready=1 -> out_data=30'h15555555, out_count=15,
//   out_valid 1 cycle after the 15th code.
//  out_ready=0, 31 codes -> first word held in out, second word stalled (count=15), 31st dropped,
//   overflow=1, drop_count=1 with DCT_DROP_COUNT_EN.
//  5 codes 2'b11 then stop -> test_ending=1, out_data=30'h3FF, out_count=5,
//   then test_has_ended=1 with test_ending=0.
//  stop and trigger in the same cycle in ARMED -> DRAIN then DONE, no word emitted.
//  Stalled buffer, then out_ready=1 with a code in the same cycle -> word emitted,
//   dct_count=1, no drop.
//  reset_n low mid-capture (count=7) -> all outputs 0 immediately, state IDLE; codes ignored until arm.

Source files
------------

// File: rtl/nios2_oci_dct_pkg.sv
// Shared definitions for the OCI debug compressed-trace (DCT) capture controller.
//   state_t : capture controller states
//   CODE_W  : bits per trace code
//   DEPTH   : codes per buffer word
//   BUF_W   : packed buffer width (CODE_W*DEPTH)
//   CNT_W   : width of the code counters (holds 0..DEPTH)
package nios2_oci_dct_pkg;

  localparam int CODE_W = 2;
  localparam int DEPTH  = 15;
  localparam int BUF_W  = CODE_W * DEPTH;
  localparam int CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/nios2_oci_dct_outreg.sv
// Single-entry valid/ready output register for DCT words.
// Holds one word (data + code count) until the sink accepts it.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   load                  : capture load_data/load_count (only asserted while free)
//   load_data, load_count : word and its number of valid codes
//   out_ready             : sink accepts when out_valid & out_ready
//   out_valid/out_data/out_count : registered word toward the sink
//   free                  : register can take a new word this cycle
module nios2_oci_dct_outreg
  import nios2_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [BUF_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [BUF_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             free
);

  // Empty, or the held word leaves this cycle, so a new one may replace it.
  assign free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_count <= load_count;
    end else if (out_ready) begin
      // Data is left in place after acceptance; only the valid flag drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_sequencer.sv
// Capture controller for the OCI debug compressed-trace (DCT) buffer.
// Arms on request, starts on trigger, packs 2-bit trace codes LSB-first into
// a 30-bit buffer and hands full (or flushed partial) words to a trace sink.
// Optional feature macro: DCT_DROP_COUNT_EN adds a saturating drop_count port.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   arm/trigger/stop     : control pulses driving the state machine
//   code_valid, code     : trace code input
//   dct_buffer/dct_count : packing buffer and its number of valid codes
//   out_valid/out_ready/out_data/out_count : word handshake toward the sink
//   overflow             : sticky, at least one code was dropped
//   test_ending          : high while draining
//   test_has_ended       : high once drained
//   drop_count           : (DCT_DROP_COUNT_EN) number of dropped codes
module nios2_oci_dct_sequencer
  import nios2_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              trigger,
  input  logic              stop,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              overflow,
  output logic              test_ending,
  output logic              test_has_ended
`ifdef DCT_DROP_COUNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  state_t           state;
  logic [BUF_W-1:0] pack_buf;
  logic [CNT_W-1:0] pack_cnt;

  logic             free;
  logic             accept;
  logic             stalled;
  logic             load;
  logic [BUF_W-1:0] load_data;
  logic [CNT_W-1:0] load_count;
  logic             drop;
  logic [BUF_W-1:0] next_buf;
  logic [CNT_W-1:0] next_cnt;

  assign dct_buffer = pack_buf;
  assign dct_count  = pack_cnt;

  // Packing datapath: decides what the buffer and output register do this cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in combinational logic infers a latch).
    accept     = code_valid &&
                 ((state == CAPTURE) || (state == ARMED && trigger && !stop));
    stalled    = (pack_cnt == CNT_W'(DEPTH));
    load       = 1'b0;
    load_data  = pack_buf;
    load_count = pack_cnt;
    drop       = 1'b0;
    next_buf   = pack_buf;
    next_cnt   = pack_cnt;

    if (state == DRAIN) begin
      // Flush whatever partial word remains.
      if (pack_cnt != '0 && free) begin
        load     = 1'b1;
        next_buf = '0;
        next_cnt = '0;
      end
    end else if (state == CAPTURE && stalled) begin
      // A full word is waiting on the output register.
      if (free) begin
        load     = 1'b1;
        next_buf = '0;
        next_cnt = '0;
        if (accept) begin
          next_buf[CODE_W-1:0] = code;
          next_cnt             = CNT_W'(1);
        end
      end else if (accept) begin
        drop = 1'b1;
      end
    end else if (accept) begin
      if (pack_cnt == CNT_W'(DEPTH - 1)) begin
        // Last slot: bypass the buffer straight into the output when possible.
        if (free) begin
          load       = 1'b1;
          load_data  = {code, pack_buf[BUF_W-CODE_W-1:0]};
          load_count = CNT_W'(DEPTH);
          next_buf   = '0;
          next_cnt   = '0;
        end else begin
          next_buf[BUF_W-1 -: CODE_W] = code;
          next_cnt                    = CNT_W'(DEPTH);
        end
      end else begin
        next_buf[int'(pack_cnt)*CODE_W +: CODE_W] = code;
        next_cnt = pack_cnt + CNT_W'(1);
      end
    end
  end

  // Control state machine plus packing state and status flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pack_buf       <= '0;
      pack_cnt       <= '0;
      overflow       <= 1'b0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
`ifdef DCT_DROP_COUNT_EN
      drop_count     <= '0;
`endif
    end else begin
      pack_buf <= next_buf;
      pack_cnt <= next_cnt;

      if (drop) begin
        overflow <= 1'b1;
`ifdef DCT_DROP_COUNT_EN
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`endif
      end

      case (state)
        IDLE: begin
          if (arm) state <= ARMED;
        end
        ARMED: begin
          // stop wins over a simultaneous trigger.
          if (stop) begin
            state       <= DRAIN;
            test_ending <= 1'b1;
          end else if (trigger) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (stop) begin
            state       <= DRAIN;
            test_ending <= 1'b1;
          end
        end
        DRAIN: begin
          if (pack_cnt == '0 && !out_valid) begin
            state          <= DONE;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b1;
          end
        end
        DONE: begin
          if (arm) begin
            state          <= ARMED;
            test_has_ended <= 1'b0;
            overflow       <= 1'b0;
`ifdef DCT_DROP_COUNT_EN
            drop_count     <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  nios2_oci_dct_outreg u_outreg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_count),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count),
    .free       (free)
  );

endmodule
